push_button_conditioner: RTL
============================

// Module: push_button_conditioner
// PURPOSE
//   Input-side counterpart of the 7-segment display driver. Converts the five raw push
//   buttons (u,d,l,r,m) into clean, clk_osc-synchronous events for the time-set,
//   alarm-set, stopwatch and alarm-check services.
//   Per button: synchroniser, debounce, press/release pulses, optional hold auto-repeat.
// PARAMETERS
//   N_BTN            5           number of buttons
//   DEBOUNCE_CYCLES  1_000_000   stable cycles required to accept a change (10 ms @100 MHz)
//   HOLD_CYCLES      50_000_000  held cycles before first auto-repeat (500 ms)
//   REPEAT_CYCLES    10_000_000  cycles between subsequent auto-repeats (100 ms)
// PORTS
//   clk_osc      in   1      system oscillator clock
//   reset        in   1      reset, asynchronous, active-low
//   btn_raw      in   N_BTN  raw buttons, active-high, asynchronous to clk_osc
//   btn_level    out  N_BTN  debounced button level
//   btn_press    out  N_BTN  1-cycle pulse on accepted press
//   btn_release  out  N_BTN  1-cycle pulse on accepted release
//   btn_step     out  N_BTN  btn_press OR auto-repeat pulse (the signal services consume)
//   any_press    out  1      OR of btn_press, same cycle
// BEHAVIOUR
//   - Reset (reset=0): all outputs 0; sync flops, debounce/hold counters 0; FSMs IDLE.
//   - Sync: 2 flops per bit. sync_q is the second flop.
//   - Debounce, per button:
//       sync_q==btn_level: counter cleared.
//       Otherwise counter increments; when counter==DEBOUNCE_CYCLES-1, btn_level toggles
//       and the counter clears.
//     A new level requires exactly DEBOUNCE_CYCLES consecutive differing samples.
//     Glitches shorter than DEBOUNCE_CYCLES produce no output.
//   - Latency: raw edge -> btn_level change = 2 + DEBOUNCE_CYCLES clk_osc cycles.
//   - btn_press/btn_release: registered, high exactly 1 cycle.
//     btn_press coincides with the first cycle btn_level=1.
//     btn_release coincides with the first cycle btn_level=0.
//   - Repeat FSM per button (counter width $clog2(max(HOLD,REPEAT))):
//       IDLE   : btn_level rises -> HELD, hold counter 0.
//       HELD   : counter==HOLD_CYCLES-1 -> repeat pulse, -> REPEAT, counter 0.
//       REPEAT : counter==REPEAT_CYCLES-1 -> repeat pulse, counter 0.
//       any state: btn_level falls -> IDLE, counter 0. No pulse emitted that cycle.
//   - btn_step = btn_press | repeat pulse; never high 2 consecutive cycles.
//   - Buttons fully independent: simultaneous presses give simultaneous pulses;
//     any_press is their OR.
//   - Reset mid-operation: outputs drop to 0 asynchronously.
//     A button held across reset release is re-debounced from level 0 and yields a
//     fresh btn_press after 2+DEBOUNCE_CYCLES cycles.
//   - Counters saturate-free: they only count within stated bounds; no wrap.
// CONFIGURATION
//   BTN_AUTOREPEAT_EN defined:
//     repeat FSM is built; btn_step carries press and repeat pulses.
//   BTN_AUTOREPEAT_EN undefined:
//     no repeat FSM or hold counters are built; btn_step == btn_press.
//     Exactly one step per press regardless of hold time.
//   All other ports and behaviour are identical in both builds.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
//   1. reset=0 with btn_raw=5'b11111 -> all outputs 0.
//      Release reset, hold btn_raw -> btn_press=5'b11111 at cycle 6, single cycle.
//   2. btn_raw[0] pulse of 3 cycles -> btn_level, btn_press, btn_step stay 0.
//   3. btn_raw[2] 1 for 10 cycles then 0 -> btn_level[2] rises at cycle 6.
//      btn_press[2] rises at cycle 6. btn_release[2] rises 6 cycles after the raw fall.
//   4. Macro on, hold btn_raw[1] for 60 cycles -> btn_step[1] at press, press+20,
//      press+28, press+36, press+44 (press+52 only if still level=1).
//      Release -> no further steps.
//   5. Macro off, same stimulus as 4 -> btn_step[1] exactly once, at press.
//   6. Assert reset=0 while in REPEAT -> outputs 0 immediately.
//      After release with button still held -> btn_press after 6 cycles;
//      first repeat only 20 cycles later.

Source files
------------

// File: rtl/push_button_conditioner.sv
// Push-button front end: per-button 2-flop synchroniser, debounce, press/release pulses.
// Optional hold auto-repeat on btn_step is built only when BTN_AUTOREPEAT_EN is defined.
module push_button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic             clk_osc,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_step,
    output logic             any_press
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
    localparam logic [RP_W-1:0] HOLD_LAST   = RP_W'(HOLD_CYCLES - 1);
    localparam logic [RP_W-1:0] REPEAT_LAST = RP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } rpt_state_e;
`endif

    logic [N_BTN-1:0] meta_q;
    logic [N_BTN-1:0] sync_q;
    logic [N_BTN-1:0] rise_vec;
    logic             any_press_d;
    logic             any_press_q;

    always_ff @(posedge clk_osc or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic            level_q;
        logic            level_d;
        logic            press_q;
        logic            release_q;
        logic            rise_d;
        logic            fall_d;

        // Counter only runs while the synchronised input disagrees with the accepted level.
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            if (sync_q[i] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_d = '0;
                level_d  = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
            rise_d = level_d & ~level_q;
            fall_d = ~level_d & level_q;
        end

        always_ff @(posedge clk_osc or negedge reset) begin
            if (!reset) begin
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= rise_d;
                release_q <= fall_d;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        rpt_state_e      state_q;
        logic [RP_W-1:0] rp_cnt_q;
        logic            step_q;

        // A falling level wins over any pending repeat so no pulse escapes on release.
        always_ff @(posedge clk_osc or negedge reset) begin
            if (!reset) begin
                state_q  <= IDLE;
                rp_cnt_q <= '0;
                step_q   <= 1'b0;
            end else begin
                step_q <= rise_d;
                if (fall_d) begin
                    state_q  <= IDLE;
                    rp_cnt_q <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (rise_d) begin
                                state_q  <= HELD;
                                rp_cnt_q <= '0;
                            end
                        end
                        HELD: begin
                            if (rp_cnt_q == HOLD_LAST) begin
                                step_q   <= 1'b1;
                                state_q  <= REPEAT;
                                rp_cnt_q <= '0;
                            end else begin
                                rp_cnt_q <= rp_cnt_q + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rp_cnt_q == REPEAT_LAST) begin
                                step_q   <= 1'b1;
                                rp_cnt_q <= '0;
                            end else begin
                                rp_cnt_q <= rp_cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q  <= IDLE;
                            rp_cnt_q <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_step[i] = step_q;
`else
        assign btn_step[i] = press_q;
`endif

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign rise_vec[i]    = rise_d;
    end

    always_comb begin
        any_press_d = |rise_vec;
    end

    always_ff @(posedge clk_osc or negedge reset) begin
        if (!reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule
